// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches from a variable-latency memory over a req/valid handshake and feeds decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    input  logic        IMemValid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic        holdValid_q, holdValid_d;
    logic [31:0] holdReg_q, holdReg_d;
    logic [31:0] instrD_q, instrD_d;
    logic [31:0] pcD_q, pcD_d;
    logic [31:0] pcPlus4D_q, pcPlus4D_d;

    logic        issue;
    logic        fresh;
    logic        avail;
    logic        transfer;
    logic [31:0] word;

    assign issue    = (state_q == IDLE) && !holdValid_q && !StallF && !PCSrcE;
    assign fresh    = (state_q == WAIT) && IMemValid;
    assign avail    = fresh || holdValid_q;
    assign word     = holdValid_q ? holdReg_q : IMemRdata;
    assign transfer = avail && !StallD && !FlushD && !PCSrcE;

    assign IMemReq  = issue && !rst;
    assign IMemAddr = pcF_q;

    assign InstrD   = instrD_q;
    assign PCD      = pcD_q;
    assign PCPlus4D = pcPlus4D_q;

    always_comb begin
        state_d     = state_q;
        pcF_d       = pcF_q;
        holdValid_d = holdValid_q;
        holdReg_d   = holdReg_q;
        instrD_d    = instrD_q;
        pcD_d       = pcD_q;
        pcPlus4D_d  = pcPlus4D_q;

        // A returned word that cannot move to decode is parked so it is never refetched.
        if (PCSrcE) begin
            pcF_d       = PCTargetE;
            holdValid_d = 1'b0;
        end else if (transfer) begin
            pcF_d       = pcF_q + 32'd4;
            holdValid_d = 1'b0;
        end else if (fresh) begin
            holdReg_d   = IMemRdata;
            holdValid_d = 1'b1;
        end

        case (state_q)
            IDLE:    if (issue) state_d = WAIT;
            WAIT:    if (IMemValid) state_d = IDLE;
                     else if (PCSrcE) state_d = DROP;
            DROP:    if (IMemValid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (FlushD || (!StallD && !transfer)) begin
            instrD_d   = NOP_INSTR;
            pcD_d      = 32'd0;
            pcPlus4D_d = 32'd0;
        end else if (transfer) begin
            instrD_d   = word;
            pcD_d      = pcF_q;
            pcPlus4D_d = pcF_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pcF_q       <= RESET_PC;
            holdValid_q <= 1'b0;
            holdReg_q   <= 32'd0;
            instrD_q    <= NOP_INSTR;
            pcD_q       <= 32'd0;
            pcPlus4D_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            holdValid_q <= holdValid_d;
            holdReg_q   <= holdReg_d;
            instrD_q    <= instrD_d;
            pcD_q       <= pcD_d;
            pcPlus4D_q  <= pcPlus4D_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/flush/redirect
// traffic against an address-tagged memory and a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemValid;
    logic [31:0] InstrD, PCD, PCPlus4D;

    int compCount = 0;
    int failCount = 0;

    logic        memPend;
    logic [31:0] memAddr;
    int          memCnt;
    int          lat;

    logic [31:0] mPc, mInstr, mPcD, mPc4D;
    logic        mOut, mStale, mHeld;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemRdata(IMemRdata), .IMemValid(IMemValid),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = RESET_PC; mOut = 1'b0; mStale = 1'b0; mHeld = 1'b0;
        mInstr = NOP; mPcD = 32'd0; mPc4D = 32'd0;
    endtask

    // One instruction in flight at most; a held word is always the word at the current PC.
    task automatic modelStep(input logic sF, sD, fD, pS, input logic [31:0] tgt, input logic v);
        logic expReq, fresh, xfer;
        expReq = !mOut && !mHeld && !sF && !pS;
        fresh  = mOut && !mStale && v;
        xfer   = (fresh || mHeld) && !sD && !fD && !pS;
        if (fD || (!sD && !xfer)) begin
            mInstr = NOP; mPcD = 32'd0; mPc4D = 32'd0;
        end else if (xfer) begin
            mInstr = wordOf(mPc); mPcD = mPc; mPc4D = mPc + 32'd4;
        end
        if (pS) begin
            mPc = tgt; mHeld = 1'b0;
        end else if (xfer) begin
            mPc = mPc + 32'd4; mHeld = 1'b0;
        end else if (fresh) begin
            mHeld = 1'b1;
        end
        if (mOut && v) begin
            mOut = 1'b0; mStale = 1'b0;
        end else if (mOut && pS) begin
            mStale = 1'b1;
        end
        if (expReq) begin
            mOut = 1'b1; mStale = 1'b0;
        end
    endtask

    task automatic checkAll();
        logic expReq;
        expReq = !rst && !mOut && !mHeld && !StallF && !PCSrcE;
        checkOutput("IMemReq", {31'd0, IMemReq}, {31'd0, expReq});
        checkOutput("IMemAddr", IMemAddr, mPc);
        checkOutput("InstrD", InstrD, mInstr);
        checkOutput("PCD", PCD, mPcD);
        checkOutput("PCPlus4D", PCPlus4D, mPc4D);
    endtask

    task automatic applyStimulus(input logic r, sF, sD, fD, pS, input logic [31:0] tgt);
        logic v;
        @(negedge clk);
        rst = r; StallF = sF; StallD = sD; FlushD = fD; PCSrcE = pS; PCTargetE = tgt;
        v = memPend && (memCnt == 0);
        IMemValid = v;
        IMemRdata = v ? wordOf(memAddr) : $urandom();
        if (r) modelReset();
        #1;
        checkAll();
        if (!r) modelStep(sF, sD, fD, pS, tgt, v);
        if (v) memPend = 1'b0;
        else if (memPend) memCnt--;
        if (IMemReq) begin
            memPend = 1'b1; memAddr = IMemAddr; memCnt = lat - 1;
        end
    endtask

    task automatic doReset();
        memPend = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    task automatic runFree(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic boundFail(input string tag);
        checkOutput(tag, 32'd1, 32'd0);
    endtask

    initial begin
        logic        seen, sd, checkNext, done, redirected, pS;
        int          left;
        logic [31:0] t;
        rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        IMemRdata = 0; IMemValid = 0; memPend = 0; memAddr = 0; memCnt = 0; lat = 1;
        modelReset();

        $display("[TB] basic streaming, latency 1 then 3");
        doReset();
        lat = 1;
        runFree(12);
        lat = 3;
        runFree(16);

        $display("[TB] decode stall while word returns for PC=8");
        doReset();
        lat = 1;
        seen = 0; left = 0; checkNext = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!seen && memPend && memCnt == 0 && memAddr == 32'h8) begin
                seen = 1; left = 3;
            end
            sd = (left > 0);
            if (left > 0) left--;
            applyStimulus(0, 0, sd, 0, 0, 0);
            if (checkNext) begin
                checkOutput("heldWord8", InstrD, wordOf(32'h8));
                done = 1;
            end else if (seen && !sd) begin
                checkNext = 1;
            end
        end
        if (!done) boundFail("heldWord8_timeout");

        $display("[TB] redirect while waiting on PC=0x10");
        doReset();
        lat = 3;
        redirected = 0; done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            pS = !redirected && memPend && memCnt > 0 && memAddr == 32'h10;
            applyStimulus(0, 0, 0, 0, pS, 32'h100);
            checkOutput("noStaleWord", {31'd0, InstrD == wordOf(32'h10)}, 32'd0);
            if (redirected && IMemReq) begin
                checkOutput("firstAddrAfterRedirect", IMemAddr, 32'h100);
                done = 1;
            end
            if (pS) redirected = 1;
        end
        if (!done) boundFail("redirectWait_timeout");
        runFree(12);

        $display("[TB] redirect coincident with return");
        doReset();
        lat = 2;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            pS = memPend && memCnt == 0 && memAddr == 32'h10;
            applyStimulus(0, 0, 0, 0, pS, 32'h100);
            if (pS) begin
                applyStimulus(0, 0, 0, 0, 0, 0);
                checkOutput("reqAfterCoincident", {31'd0, IMemReq}, 32'd1);
                checkOutput("addrAfterCoincident", IMemAddr, 32'h100);
                done = 1;
            end
        end
        if (!done) boundFail("coincident_timeout");
        runFree(6);

        $display("[TB] reset in the middle of an outstanding fetch");
        doReset();
        lat = 3;
        runFree(6);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (memPend && memCnt > 0) done = 1;
            else applyStimulus(0, 0, 0, 0, 0, 0);
        end
        if (!done) boundFail("midWait_timeout");
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("resetPC", IMemAddr, RESET_PC);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            if (!memPend) done = 1;
        end
        if (!done) boundFail("lateValid_timeout");
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("firstReqAfterReset", {31'd0, IMemReq}, 32'd1);
        checkOutput("firstAddrAfterReset", IMemAddr, RESET_PC);
        runFree(4);

        $display("[TB] PC wrap at top of address space");
        lat = 1;
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (InstrD == wordOf(32'hFFFF_FFFC)) begin
                checkOutput("wrapPCD", PCD, 32'hFFFF_FFFC);
                checkOutput("wrapPCPlus4D", PCPlus4D, 32'd0);
                checkOutput("wrapNextAddr", IMemAddr, 32'd0);
                done = 1;
            end
        end
        if (!done) boundFail("wrap_timeout");
        runFree(4);

        $display("[TB] random hazards and redirects");
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (!memPend) lat = $urandom_range(1, 4);
            t = $urandom() & 32'hFFFF_FFFC;
            applyStimulus(0, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 8), t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
